// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for the pipelined rvcpu core.
// Reads are combinational and bypass a same-cycle writeback. A small per-register
// up/down counter tracks issued-but-not-retired writes so that ID can see hazards
// (r_busy) and stall issue when a register already has the maximum in flight.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        r_ena,
  input  logic [NUM_RD*AW-1:0]     r_addr,
  output logic [NUM_RD*XLEN-1:0]   r_data,
  output logic [NUM_RD-1:0]        r_busy,
  input  logic                     w_ena,
  input  logic [AW-1:0]            w_addr,
  input  logic [XLEN-1:0]          w_data,
  input  logic                     iss_ena,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ready,
  input  logic                     flush
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] cnt_q  [NREG];
  logic [CNT_W-1:0] cnt_d  [NREG];
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;

  // Saturating-free counter step: callers guarantee inc never hits max and dec never hits 0.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic inc,
                                                 input logic dec,
                                                 input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr)              nxt = '0;
    else if (inc && !dec) nxt = CNT_W'(cur + 1'b1);
    else if (dec && !inc) nxt = CNT_W'(cur - 1'b1);
    return nxt;
  endfunction

  // Issue is refused only when the destination counter is full; x0 never tracks anything.
  assign iss_ready = rst || (iss_addr == '0) || (cnt_q[iss_addr] != CNT_MAX);

  // Read ports: disabled or x0 reads return zero; a same-cycle writeback is forwarded.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          live;
    assign ra   = r_addr[k*AW +: AW];
    assign live = r_ena[k] && (ra != '0) && !rst;
    assign r_data[k*XLEN +: XLEN] = !live ? '0 :
                                    (w_ena && (w_addr == ra)) ? w_data : regs_q[ra];
    assign r_busy[k] = live && (cnt_q[ra] != '0);
  end

  // Next register contents: writeback commits regardless of scoreboard state; x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (w_ena && (w_addr != '0)) regs_d[w_addr] = w_data;
    regs_d[0] = '0;
  end

  // Next scoreboard counts: issue increments, retire decrements, flush clears everything.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_v[i] = iss_ena && iss_ready && (iss_addr != '0) && (iss_addr == AW'(i));
      dec_v[i] = w_ena && (w_addr == AW'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_next(cnt_q[i], inc_v[i], dec_v[i], flush);
    end
    cnt_d[0] = '0;
  end

  // State registers; reset clears both data and pending counts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (3 read ports): directed vectors, scoreboard queue
// filled by the stimulus process and drained by a negedge monitor.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int AW   = 5;

  localparam int K_DATA  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_READY = 2;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [63:0] val;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NRD-1:0]       r_ena = '0;
  logic [NRD*AW-1:0]    r_addr = '0;
  logic [NRD*XLEN-1:0]  r_data;
  logic [NRD-1:0]       r_busy;
  logic                 w_ena = 1'b0;
  logic [AW-1:0]        w_addr = '0;
  logic [XLEN-1:0]      w_data = '0;
  logic                 iss_ena = 1'b0;
  logic [AW-1:0]        iss_addr = '0;
  logic                 iss_ready;
  logic                 flush = 1'b0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NRD), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data),
    .r_busy(r_busy), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .iss_ena(iss_ena), .iss_addr(iss_addr), .iss_ready(iss_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  // Monitor: every negedge, compare all pending expectations against the outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        K_DATA:  act = r_data[e.port*XLEN +: XLEN];
        K_BUSY:  act = {63'd0, r_busy[e.port]};
        default: act = {63'd0, iss_ready};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int k, input logic e, input logic [AW-1:0] a);
    r_ena[k] = e;
    r_addr[k*AW +: AW] = a;
  endtask

  task automatic wr(input logic e, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    w_ena = e; w_addr = a; w_data = d;
  endtask

  task automatic iss(input logic e, input logic [AW-1:0] a);
    iss_ena = e; iss_addr = a;
  endtask

  task automatic expect_v(input string n, input int kind, input int port, input logic [63:0] v);
    exp_t e;
    e.name = n; e.kind = kind; e.port = port; e.val = v;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write/read with bypass
    step(); wr(1, 5, 64'hDEAD_BEEF); rd(0, 1, 5);
    expect_v("bypass_data", K_DATA, 0, 64'hDEAD_BEEF);
    expect_v("bypass_busy", K_BUSY, 0, 0);
    step(); wr(0, 0, 0);
    expect_v("stored_data", K_DATA, 0, 64'hDEAD_BEEF);

    // x0: writes and issues are ignored; disabled port reads zero
    step(); wr(1, 0, 64'h1234); iss(1, 0); rd(0, 1, 0); rd(1, 0, 5);
    expect_v("x0_bypass", K_DATA, 0, 0);
    expect_v("x0_ready", K_READY, 0, 1);
    expect_v("disabled_port", K_DATA, 1, 0);
    step(); wr(0, 0, 0); iss(0, 0);
    expect_v("x0_data", K_DATA, 0, 0);
    expect_v("x0_busy", K_BUSY, 0, 0);

    // Scoreboard fill to max on reg 7
    step(); iss(1, 7); rd(0, 1, 7);
    expect_v("sb_rdy0", K_READY, 0, 1);
    expect_v("sb_busy0", K_BUSY, 0, 0);
    step();
    expect_v("sb_rdy1", K_READY, 0, 1);
    expect_v("sb_busy1", K_BUSY, 0, 1);
    step();
    expect_v("sb_rdy2", K_READY, 0, 1);
    step();
    expect_v("sb_full", K_READY, 0, 0);
    expect_v("sb_full_busy", K_BUSY, 0, 1);
    step(); iss(0, 7); wr(1, 7, 64'h70);
    expect_v("retire_no_sub_busy", K_BUSY, 0, 1);
    expect_v("retire_no_raise_rdy", K_READY, 0, 0);
    expect_v("retire_bypass", K_DATA, 0, 64'h70);
    step(); wr(1, 7, 64'h71);
    expect_v("after_ret1_rdy", K_READY, 0, 1);
    expect_v("after_ret1_busy", K_BUSY, 0, 1);
    step(); wr(1, 7, 64'h72);
    expect_v("after_ret2_busy", K_BUSY, 0, 1);
    step(); wr(1, 7, 64'h73);
    expect_v("after_ret3_busy", K_BUSY, 0, 0);
    expect_v("write_at_cnt0_byp", K_DATA, 0, 64'h73);
    step(); wr(0, 0, 0);
    expect_v("no_wrap_busy", K_BUSY, 0, 0);
    expect_v("no_wrap_rdy", K_READY, 0, 1);
    expect_v("write_at_cnt0_data", K_DATA, 0, 64'h73);

    // Simultaneous issue and retire on reg 9
    step(); iss(1, 9); rd(1, 1, 9);
    step(); wr(1, 9, 64'h99);
    expect_v("simul_busy", K_BUSY, 1, 1);
    expect_v("simul_byp", K_DATA, 1, 64'h99);
    step(); iss(0, 0); wr(0, 0, 0);
    expect_v("simul_busy_after", K_BUSY, 1, 1);
    expect_v("simul_data_after", K_DATA, 1, 64'h99);

    // Flush with cnt[3]=2, cnt[4]=1, cnt[9]=1
    step(); iss(1, 3);
    step();
    step(); iss(1, 4);
    step(); iss(1, 3); rd(0, 1, 3); rd(1, 1, 4); rd(2, 1, 9);
    flush = 1'b1; wr(1, 3, 64'h55);
    expect_v("pre_flush_b3", K_BUSY, 0, 1);
    expect_v("pre_flush_b4", K_BUSY, 1, 1);
    expect_v("pre_flush_b9", K_BUSY, 2, 1);
    step(); flush = 1'b0; wr(0, 0, 0); iss(0, 0);
    expect_v("flush_b3", K_BUSY, 0, 0);
    expect_v("flush_b4", K_BUSY, 1, 0);
    expect_v("flush_b9", K_BUSY, 2, 0);
    expect_v("flush_data3", K_DATA, 0, 64'h55);

    // Multi-port: regs 1,1,2
    step(); wr(1, 1, 64'h11);
    step(); wr(1, 2, 64'h22); iss(1, 2);
    step(); wr(0, 0, 0); iss(0, 0); rd(0, 1, 1); rd(1, 1, 1); rd(2, 1, 2);
    expect_v("mp_d0", K_DATA, 0, 64'h11);
    expect_v("mp_d1", K_DATA, 1, 64'h11);
    expect_v("mp_d2", K_DATA, 2, 64'h22);
    expect_v("mp_b0", K_BUSY, 0, 0);
    expect_v("mp_b1", K_BUSY, 1, 0);
    expect_v("mp_b2", K_BUSY, 2, 1);

    // Reset mid-cycle, with a bypassing write and a busy register present
    step(); wr(1, 2, 64'hAA); rd(0, 1, 1); rd(1, 1, 2); rd(2, 1, 5); iss(0, 2);
    #1 rst = 1'b1;
    expect_v("rst_d0", K_DATA, 0, 0);
    expect_v("rst_d1", K_DATA, 1, 0);
    expect_v("rst_d2", K_DATA, 2, 0);
    expect_v("rst_b1", K_BUSY, 1, 0);
    expect_v("rst_rdy", K_READY, 0, 1);
    @(negedge clk);
    #2 wr(0, 0, 0); rst = 1'b0;
    step();
    expect_v("post_rst_d0", K_DATA, 0, 0);
    expect_v("post_rst_d1", K_DATA, 1, 0);
    expect_v("post_rst_d2", K_DATA, 2, 0);
    expect_v("post_rst_b1", K_BUSY, 1, 0);

    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
